// File: rtl/bch_enc_pkg.sv
// Shared constants, FSM state type and helpers for the streaming BCH encoder.
package bch_enc_pkg;

    // t=2 BCH generator over GF(2^7), primitive polynomial x^7+x^3+1
    localparam logic [14:0] GPOLY_DEF = 15'h4377;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bch_enc_stream_if.sv
// Valid/ready input and output streams of the BCH encoder.
interface bch_enc_stream_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bch_lfsr_step.sv
// Folds W message bits (MSB first) into the R-bit division remainder in one cycle.
module bch_lfsr_step
    import bch_enc_pkg::*;
#(
    parameter int         R     = 14,
    parameter int         W     = 8,
    parameter logic [R:0] GPOLY = (R+1)'(GPOLY_DEF)
) (
    input  logic [R-1:0] rem,
    input  logic [W-1:0] data,
    output logic [R-1:0] rem_nxt
);

    logic [R-1:0] r;
    logic         fb;

    always_comb begin
        r  = rem;
        fb = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            fb = data[i] ^ r[R-1];
            r  = (r << 1) ^ (fb ? GPOLY[R-1:0] : '0);
        end
        rem_nxt = r;
    end

endmodule

// File: rtl/bch_enc_stream.sv
// Systematic streaming BCH encoder: echoes K/W data beats, then appends ceil(R/W) parity beats.
module bch_enc_stream
    import bch_enc_pkg::*;
#(
    parameter int         K     = 112,
    parameter int         R     = 14,
    parameter int         W     = 8,
    parameter logic [R:0] GPOLY = (R+1)'(GPOLY_DEF)
) (
    input logic             clk,
    input logic             rst_n,
    bch_enc_stream_if.slave s
);

    localparam int NB  = K / W;
    localparam int P   = ceil_div(R, W);
    localparam int PW  = P * W;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PCW = (P > 1) ? $clog2(P) : 1;

    state_t         state, state_nxt;
    logic [R-1:0]   rem, rem_step;
    logic [BW-1:0]  bcnt;
    logic [PCW-1:0] pcnt;
    logic           ovld, olast, rdy;
    logic [W-1:0]   odata, par_beat;
    logic [PW-1:0]  par_pad;
    logic           out_free, in_fire, par_load, last_data, last_par;

    assign s.out_valid = ovld;
    assign s.out_data  = odata;
    assign s.out_last  = olast;
    assign s.in_ready  = rdy;

    assign out_free  = !ovld || s.out_ready;
    assign last_data = (bcnt == BW'(NB - 1));
    assign last_par  = (pcnt == PCW'(P - 1));

    bch_lfsr_step #(.R(R), .W(W), .GPOLY(GPOLY)) u_step (
        .rem     (rem),
        .data    (s.in_data),
        .rem_nxt (rem_step)
    );

    // Remainder left-aligned in P*W bits so a short final beat is zero-padded in its LSBs
    always_comb begin
        par_pad  = PW'(rem) << (PW - R);
        par_beat = par_pad[(P - 1 - int'(pcnt)) * W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_DATA;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        in_fire   = 1'b0;
        par_load  = 1'b0;
        case (state)
            ST_DATA: begin
                rdy     = out_free;
                in_fire = s.in_valid && out_free;
                if (in_fire && last_data) state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
                par_load = out_free;
                if (par_load && last_par) state_nxt = ST_DATA;
            end
            default: state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovld  <= 1'b0;
            olast <= 1'b0;
            odata <= '0;
            rem   <= '0;
            bcnt  <= '0;
            pcnt  <= '0;
        end else if (in_fire) begin
            ovld  <= 1'b1;
            olast <= 1'b0;
            odata <= s.in_data;
            rem   <= rem_step;
            bcnt  <= last_data ? '0 : bcnt + 1'b1;
        end else if (par_load) begin
            ovld  <= 1'b1;
            olast <= last_par;
            odata <= par_beat;
            if (last_par) begin
                rem  <= '0;
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end else if (s.out_ready) begin
            ovld  <= 1'b0;
            olast <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bch_enc_stream.sv
// Scoreboard bench for bch_enc_stream: W=8 main instance plus W=1/W=2 parity cross-check.
module tb_bch_enc_stream;
    import bch_enc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bch_enc_stream_if #(.W(8)) b8 ();
    bch_enc_stream_if #(.W(1)) b1 ();
    bch_enc_stream_if #(.W(2)) b2 ();

    bch_enc_stream #(.K(112), .R(14), .W(8)) dut  (.clk(clk), .rst_n(rst_n), .s(b8));
    bch_enc_stream #(.K(112), .R(14), .W(1)) dut1 (.clk(clk), .rst_n(rst_n), .s(b1));
    bch_enc_stream #(.K(112), .R(14), .W(2)) dut2 (.clk(clk), .rst_n(rst_n), .s(b2));

    localparam logic [14:0] G = 15'h4377;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ob_t;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] stim_q[$];
    ob_t        exp_q[$];

    int           obeat = 0, cyc = 0, n_out = 0;
    int           first_in = -1, first_out = -1, last_out = -1;
    logic [127:0] cw = '0;
    logic         stall_en = 1'b0;
    int           stall_left = 0, stalled_beat = -1;
    logic [7:0]   held = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Long division of an n-bit polynomial by G, returning the 14-bit remainder
    function automatic logic [13:0] poly_mod(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 14; i--)
            if (v[i]) v ^= (128'(G) << (i - 14));
        return v[13:0];
    endfunction

    task automatic push_frame(input logic [111:0] d);
        logic [13:0] p;
        logic [15:0] pp;
        for (int j = 0; j < 14; j++) begin
            stim_q.push_back(d[111 - 8*j -: 8]);
            exp_q.push_back(ob_t'{d: d[111 - 8*j -: 8], l: 1'b0});
        end
        p  = poly_mod(128'({d, 14'b0}), 126);
        pp = {p, 2'b00};
        exp_q.push_back(ob_t'{d: pp[15:8], l: 1'b0});
        exp_q.push_back(ob_t'{d: pp[7:0],  l: 1'b1});
    endtask

    // One clock: drive at the falling edge, then account for transfers at the next rising edge
    task automatic step();
        ob_t e;
        logic fresh;
        fresh = 1'b0;
        if (stall_en && b8.out_valid && stall_left == 0 &&
            (obeat == 5 || obeat == 14) && stalled_beat != obeat) begin
            stall_left   = 3;
            stalled_beat = obeat;
            held         = b8.out_data;
            fresh        = 1'b1;
        end
        b8.out_ready = (stall_left == 0);
        if (stim_q.size() > 0) begin
            b8.in_valid = 1'b1;
            b8.in_data  = stim_q[0];
        end else begin
            b8.in_valid = 1'b0;
            b8.in_data  = '0;
        end
        #1;
        if (stall_left > 0) begin
            chk("stall_in_ready", b8.in_ready, 0);
            if (!fresh) chk("stall_hold", b8.out_data, held);
            stall_left--;
        end
        if (b8.in_valid && b8.in_ready) begin
            void'(stim_q.pop_front());
            if (first_in < 0) first_in = cyc;
        end
        if (b8.out_valid && b8.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", b8.out_data, e.d);
                chk("out_last", b8.out_last, e.l);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_out++;
            obeat++;
            cw = {cw[119:0], b8.out_data};
            if (b8.out_last) begin
                chk("codeword_div", poly_mod(cw >> 2, 126), 0);
                obeat        = 0;
                stalled_beat = -1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_frames(input int limit);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < limit) begin
            step();
            g++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [111:0] rf;
        logic [15:0]  ref_par, t2_par;
        int           g, n0;
        int           acc1, acc2, nb1, nb2, last1, last2;
        logic [13:0]  p1, p2;

        b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_out_data",  b8.out_data,  0);
        chk("rst_out_last",  b8.out_last,  0);
        chk("rst_in_ready",  b8.in_ready,  1);
        rst_n = 1'b1;
        @(negedge clk);

        // all-zero frame, then single trailing one, with first-beat latency
        push_frame('0);
        run_frames(100);
        chk("zero_parity", cw[15:0], 16'h0000);
        chk("latency", first_out - first_in, 1);

        push_frame(112'h1);
        run_frames(100);
        t2_par = cw[15:0];
        chk("one_parity", t2_par, 16'h0DDC);

        // same random frame without and with output stalls
        rf = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        push_frame(rf);
        run_frames(100);
        ref_par = cw[15:0];
        stall_en = 1'b1;
        push_frame(rf);
        run_frames(100);
        stall_en = 1'b0;
        chk("stall_parity", cw[15:0], ref_par);
        chk("stall_count", stalled_beat, -1);

        // three back-to-back frames must stream without bubbles
        first_out = -1;
        n0 = n_out;
        for (int f = 0; f < 3; f++)
            push_frame(112'({$urandom(), $urandom(), $urandom(), $urandom()}));
        run_frames(200);
        chk("b2b_beats",  n_out - n0, 48);
        chk("b2b_cycles", last_out - first_out + 1, 48);

        // reset while parity beat 0 is presented
        push_frame(112'({$urandom(), $urandom(), $urandom(), $urandom()}));
        g = 0;
        while (!(obeat == 14 && b8.out_valid) && g < 100) begin
            step();
            g++;
        end
        chk("reach_parity", g < 100, 1);
        b8.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", b8.out_valid, 0);
        chk("arst_out_data",  b8.out_data,  0);
        chk("arst_out_last",  b8.out_last,  0);
        chk("arst_in_ready",  b8.in_ready,  1);
        stim_q.delete();
        exp_q.delete();
        obeat = 0;
        stalled_beat = -1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame('0);
        run_frames(100);
        chk("post_rst_parity", cw[15:0], 16'h0000);

        // narrow beat widths must give the same 14 parity bits
        acc1 = 0; acc2 = 0; nb1 = 0; nb2 = 0; last1 = -1; last2 = -1;
        p1 = '0; p2 = '0;
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            b1.in_valid = (acc1 < 112);
            b1.in_data  = 1'(acc1 == 111);
            b2.in_valid = (acc2 < 56);
            b2.in_data  = (acc2 == 55) ? 2'b01 : 2'b00;
            #1;
            if (b1.in_valid && b1.in_ready) acc1++;
            if (b2.in_valid && b2.in_ready) acc2++;
            if (b1.out_valid) begin
                if (nb1 >= 112) p1 = {p1[12:0], b1.out_data};
                if (b1.out_last) last1 = nb1;
                nb1++;
            end
            if (b2.out_valid) begin
                if (nb2 >= 56) p2 = {p2[11:0], b2.out_data};
                if (b2.out_last) last2 = nb2;
                nb2++;
            end
            @(negedge clk);
        end
        chk("w1_parity", p1, 14'h0377);
        chk("w2_parity", p2, 14'h0377);
        chk("w1_vs_w8",  p1, t2_par[15:2]);
        chk("w1_beats",  nb1, 126);
        chk("w2_beats",  nb2, 63);
        chk("w1_last",   last1, 125);
        chk("w2_last",   last2, 62);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bch_enc_stream.md
BCH_ENC_STREAM -- requirements
Module: bch_enc_stream

Interface
REQ-001 Parameter K, default 112: data bits per codeword (shortened code, K+R <= 127); SHALL satisfy K % W == 0.
REQ-002 Parameter R, default 14: parity bits per codeword, equal to the generator degree.
REQ-003 Parameter W, default 8: bits per beat; 1 <= W <= K.
REQ-004 Parameter GPOLY, default 15'h4377 (octal 41567, t=2 BCH, primitive x^7+x^3+1): generator polynomial, R+1 bits, bit R and bit 0 set.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  encoder accepts input beat.
REQ-009 in_data  in  W  data beat; in_data[W-1] is the highest-degree (earliest) bit.
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream accepts output beat.
REQ-012 out_data  out  W  codeword beat, systematic: data beats then parity beats.
REQ-013 out_last  out  1  high on the final parity beat of a codeword.

Function
REQ-014 Transfers occur on valid&ready at a rising clk; a held beat SHALL keep out_data/out_last stable until accepted.
REQ-015 Output is one registered stage: an accepted input beat appears on out_data exactly 1 cycle later.
REQ-016 FSM states: DATA and PARITY; reset state DATA.
REQ-017 DATA: in_ready = !out_valid || out_ready; each accepted beat is loaded unchanged into the output register and folds into remainder rem[R-1:0].
REQ-018 Per-beat update, for i = W-1 down to 0: fb = in_data[i] ^ rem[R-1]; rem = (rem << 1) ^ (fb ? GPOLY[R-1:0] : 0).
REQ-019 Beat counter counts accepted data beats 0..K/W-1; acceptance of beat K/W-1 SHALL move the FSM to PARITY with rem already including that beat.
REQ-020 PARITY: in_ready = 0; P = ceil(R/W) beats are loaded whenever the output register is empty or being accepted, MSB first: rem[R-1:R-W], then the next W bits.
REQ-021 If R % W != 0, the final parity beat carries the remaining bits in its MSBs and zeros in its LSBs.
REQ-022 out_last = 1 only on parity beat P-1; loading that beat SHALL clear rem and the counters and return the FSM to DATA.
REQ-023 Back-to-back frames with out_ready held high: the first data beat of the next frame is accepted in the cycle after the last parity beat is loaded, giving K/W+P cycles per codeword with no bubble.
REQ-024 When in_valid=0 the output register, rem and counters SHALL hold; no timeout.

Reset
REQ-025 rst_n low SHALL immediately set out_valid=0, out_last=0, out_data=0, rem=0, both counters=0, FSM=DATA; in_ready is then 1.
REQ-026 Reset asserted mid-frame or mid-parity SHALL discard the partial codeword; the first beat after deassertion starts a new codeword.

Structure
REQ-027 Package bch_enc_pkg SHALL hold the default GPOLY constant, the state enum, and a ceil-divide function used to compute P.
REQ-028 Sub-module bch_lfsr_step SHALL implement the combinational W-bit remainder update of REQ-018 (parameters R, W, GPOLY); bch_enc_stream instantiates it once.

Verification (defaults K=112, R=14, W=8, so P=2)
REQ-029 All-zero frame of 14 beats, out_ready=1 -> 14 data beats echoed, then parity 0x00, 0x00 with out_last on the second.
REQ-030 Beats 0..12 = 0x00, beat 13 = 0x01 -> parity 0x0D, 0xDC (rem = 14'h0377 = GPOLY[13:0]).
REQ-031 out_ready held low 3 cycles during data beat 5 and again during parity beat 0 -> out_data held stable, in_ready=0 throughout, no beat lost or duplicated, parity unchanged versus the no-stall run.
REQ-032 Three back-to-back random frames, out_ready=1 -> 48 output beats in 48 cycles; parity matches a software polynomial-division model; every codeword is divisible by GPOLY.
REQ-033 rst_n pulsed low during parity beat 0 -> outputs zero asynchronously; the next all-zero frame yields parity 0x00, 0x00.
REQ-034 Re-run REQ-030 with W=1 and W=2 -> identical 14 parity bits, with beat counts 112+14 and 56+7.
